// File: rtl/vl53l0x_range_seq.sv
// VL53L0X single-shot ranging scheduler: trigger, poll status,
// read the 16-bit range, clear the interrupt, publish, wait a period.
module vl53l0x_range_seq #(
  parameter int PERIOD_CYCLES   = 1300000,
  parameter int POLL_GAP_CYCLES = 6500,
  parameter int MAX_POLLS       = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        init_done,
  output logic        write_start,
  input  logic        write_done,
  output logic        read_start,
  input  logic        read_done,
  output logic [7:0]  reg_addr,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic [3:0]  n_bytes,
  output logic [15:0] range_mm,
  output logic        range_valid,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = $clog2(PERIOD_CYCLES + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);

  localparam logic [CW-1:0] PER_TC  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(POLL_GAP_CYCLES - 1);
  localparam logic [PW-1:0] POLL_TC = PW'(MAX_POLLS);

  typedef enum logic [3:0] {
    IDLE, START_W, START_WAIT, POLL_R, POLL_WAIT, GAP,
    RES_R, RES_WAIT, CLR_W, CLR_WAIT, PUBLISH, PERIOD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] poll_cnt, poll_n, poll_inc;
  logic [7:0]    hi, hi_n, lo, lo_n;
  logic          lo_sel, lo_sel_n;
  logic          res_ok, res_ok_n;
  logic          wr_n, rd_n, rv_n, to_n;
  logic [7:0]    addr_n, dout_n;
  logic [3:0]    nb_n;
  logic [15:0]   rng_n;

  assign poll_inc = poll_cnt + PW'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      poll_cnt    <= '0;
      hi          <= '0;
      lo          <= '0;
      lo_sel      <= 1'b0;
      res_ok      <= 1'b0;
      write_start <= 1'b0;
      read_start  <= 1'b0;
      reg_addr    <= '0;
      data_out    <= '0;
      n_bytes     <= '0;
      range_mm    <= '0;
      range_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      poll_cnt    <= poll_n;
      hi          <= hi_n;
      lo          <= lo_n;
      lo_sel      <= lo_sel_n;
      res_ok      <= res_ok_n;
      write_start <= wr_n;
      read_start  <= rd_n;
      reg_addr    <= addr_n;
      data_out    <= dout_n;
      n_bytes     <= nb_n;
      range_mm    <= rng_n;
      range_valid <= rv_n;
      timeout_err <= to_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    poll_n   = poll_cnt;
    hi_n     = hi;
    lo_n     = lo;
    lo_sel_n = lo_sel;
    res_ok_n = res_ok;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    rv_n     = 1'b0;
    to_n     = 1'b0;
    addr_n   = reg_addr;
    dout_n   = data_out;
    nb_n     = n_bytes;
    rng_n    = range_mm;
    unique case (state)
      IDLE: begin
        if (enable && init_done) state_n = START_W;
      end
      START_W: begin
        wr_n     = 1'b1;
        addr_n   = 8'h00;
        dout_n   = 8'h01;
        res_ok_n = 1'b0;
        state_n  = START_WAIT;
      end
      START_WAIT: begin
        if (write_done) begin
          poll_n  = '0;
          state_n = POLL_R;
        end
      end
      POLL_R: begin
        rd_n    = 1'b1;
        addr_n  = 8'h13;
        nb_n    = 4'd1;
        state_n = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (read_done) begin
          if (|data_in[2:0]) begin
            state_n = RES_R;
          end else begin
            poll_n = poll_inc;
            if (poll_inc == POLL_TC) begin
              to_n    = 1'b1;
              state_n = CLR_W;
            end else begin
              state_n = GAP;
            end
          end
        end
      end
      GAP: begin
        if (cnt == GAP_TC) begin
          cnt_n   = '0;
          state_n = POLL_R;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RES_R: begin
        rd_n     = 1'b1;
        addr_n   = 8'h1E;
        nb_n     = 4'd2;
        lo_sel_n = 1'b0;
        state_n  = RES_WAIT;
      end
      RES_WAIT: begin
        if (read_done) begin
          if (!lo_sel) begin
            hi_n     = data_in;
            lo_sel_n = 1'b1;
          end else begin
            lo_n     = data_in;
            res_ok_n = 1'b1;
            state_n  = CLR_W;
          end
        end
      end
      CLR_W: begin
        wr_n    = 1'b1;
        addr_n  = 8'h0B;
        dout_n  = 8'h01;
        state_n = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (write_done) state_n = res_ok ? PUBLISH : PERIOD;
      end
      PUBLISH: begin
        rng_n   = {hi, lo};
        rv_n    = 1'b1;
        state_n = PERIOD;
      end
      PERIOD: begin
        // dropping enable here is the only way the sequencer stops
        if (!enable) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == PER_TC) begin
          cnt_n   = '0;
          state_n = START_W;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vl53l0x_range_seq.sv
// Scoreboard bench for vl53l0x_range_seq with a behavioural
// register-op engine and a measurement-level reference model.
module tb_vl53l0x_range_seq;

  localparam int P   = 200;
  localparam int G   = 20;
  localparam int MP  = 4;
  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        init_done = 1'b0;
  logic        write_start, write_done;
  logic        read_start, read_done;
  logic [7:0]  reg_addr, data_out, data_in;
  logic [3:0]  n_bytes;
  logic [15:0] range_mm;
  logic        range_valid, timeout_err, busy;

  always #5 clk = ~clk;

  vl53l0x_range_seq #(
    .PERIOD_CYCLES(P),
    .POLL_GAP_CYCLES(G),
    .MAX_POLLS(MP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .init_done(init_done),
    .write_start(write_start),
    .write_done(write_done),
    .read_start(read_start),
    .read_done(read_done),
    .reg_addr(reg_addr),
    .data_out(data_out),
    .data_in(data_in),
    .n_bytes(n_bytes),
    .range_mm(range_mm),
    .range_valid(range_valid),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] val;
    int         gap;
  } op_t;

  typedef struct {
    bit          is_rng;
    logic [15:0] rng;
  } ev_t;

  op_t        exp_ops[$];
  ev_t        exp_ev[$];
  logic [7:0] stat_q[$];
  logic [7:0] rng_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  bit          m_first = 1'b1;
  bit          m_pub = 1'b0;
  logic [15:0] m_range = '0;

  // engine bookkeeping
  bit         spur_en = 1'b0;
  int         inject = 0;
  int         poll_seen = 0;
  int         res_bytes = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(bit wr, logic [7:0] a, logic [7:0] v, int g);
    op_t o;
    o.wr = wr; o.addr = a; o.val = v; o.gap = g;
    return o;
  endfunction

  // One measurement: nz not-ready polls then rdy; gaps are cycles
  // from the previous op's last done to this op's start pulse.
  task automatic queue_meas(input int nz, input logic [7:0] rdy,
                            input logic [15:0] rng, input logic [7:0] nr_mask);
    int polls = 0;
    bit ready = 1'b0;
    logic [7:0] st;
    ev_t e;
    exp_ops.push_back(mk_op(1'b1, 8'h00, 8'h01,
                            m_first ? -1 : (m_pub ? P + 3 : P + 2)));
    m_first = 1'b0;
    while (1) begin
      st = (polls < nz) ? (8'($urandom) & 8'hF8 & nr_mask) : rdy;
      exp_ops.push_back(mk_op(1'b0, 8'h13, 8'd1, polls == 0 ? 2 : G + 2));
      stat_q.push_back(st);
      polls++;
      if (st[2:0] != 3'b000) begin
        ready = 1'b1;
        break;
      end
      if (polls == MP) break;
    end
    if (ready) begin
      exp_ops.push_back(mk_op(1'b0, 8'h1E, 8'd2, 2));
      rng_q.push_back(rng[15:8]);
      rng_q.push_back(rng[7:0]);
      m_range = rng;
    end
    exp_ops.push_back(mk_op(1'b1, 8'h0B, 8'h01, 2));
    e.is_rng = ready;
    e.rng = m_range;
    exp_ev.push_back(e);
    m_pub = ready;
  endtask

  // register-op engine plus op monitor
  initial begin
    bit         pend = 1'b0;
    bit         pend_wr = 1'b0;
    logic [7:0] pend_addr = '0;
    int         pend_cnt = 0;
    int         pend_left = 0;
    int         last_done = -1;
    op_t        e;
    write_done = 1'b0;
    read_done  = 1'b0;
    data_in    = '0;
    forever begin
      @(posedge clk);
      #1;
      write_done = 1'b0;
      read_done  = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (write_start || read_start) begin
        check("op_overlap", {31'd0, pend}, 0);
        check("op_both", {31'd0, write_start & read_start}, 0);
        if (exp_ops.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op: wr=%0b addr=%0h expected none",
                   write_start, reg_addr);
        end else begin
          e = exp_ops.pop_front();
          check("op_kind", {31'd0, write_start}, {31'd0, e.wr});
          check("op_addr", reg_addr, e.addr);
          check("op_val", write_start ? data_out : {4'h0, n_bytes}, e.val);
          if (e.gap >= 0) check("op_gap", cyc - last_done, e.gap);
        end
        pend      = 1'b1;
        pend_wr   = write_start;
        pend_addr = reg_addr;
        pend_cnt  = LAT;
        pend_left = write_start ? 1 : ((n_bytes == 0) ? 1 : int'(n_bytes));
        if (read_start && reg_addr == 8'h13) poll_seen++;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          check("hold_addr", reg_addr, pend_addr);
          if (pend_wr) begin
            write_done = 1'b1;
          end else begin
            read_done = 1'b1;
            if (pend_addr == 8'h13) begin
              data_in = (stat_q.size() != 0) ? stat_q.pop_front() : 8'h00;
            end else begin
              data_in = (rng_q.size() != 0) ? rng_q.pop_front() : 8'h00;
              res_bytes++;
            end
          end
          last_done = cyc;
          pend_left--;
          if (pend_left <= 0) pend = 1'b0;
          else pend_cnt = 1;
        end
      end else if (inject > 0 || (spur_en && $urandom_range(7) == 0)) begin
        write_done = 1'b1;
        read_done  = 1'b1;
        data_in    = 8'($urandom) | 8'h07;
        if (inject > 0) inject--;
      end
    end
  end

  // result/timeout monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (range_valid || timeout_err)) begin
        if (exp_ev.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: rv=%0b to=%0b expected none",
                   range_valid, timeout_err);
        end else begin
          e = exp_ev.pop_front();
          check("ev_valid", {31'd0, range_valid}, {31'd0, e.is_rng});
          check("ev_timeout", {31'd0, timeout_err}, {31'd0, !e.is_rng});
          check("ev_range", range_mm, e.rng);
        end
      end
    end
  end

  task automatic outs_zero(input string t);
    check({t, "_wstart"}, write_start, 0);
    check({t, "_rstart"}, read_start, 0);
    check({t, "_addr"}, reg_addr, 0);
    check({t, "_dout"}, data_out, 0);
    check({t, "_nbytes"}, n_bytes, 0);
    check({t, "_range"}, range_mm, 0);
    check({t, "_rvalid"}, range_valid, 0);
    check({t, "_tout"}, timeout_err, 0);
    check({t, "_busy"}, busy, 0);
  endtask

  task automatic drain_all(input int lim);
    int n = 0;
    while ((exp_ops.size() != 0 || exp_ev.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_ops.size() + exp_ev.size(), 0);
  endtask

  task automatic stop_after();
    drain_all(20000);
    enable = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("stop_busy", busy, 0);
    m_first = 1'b1;
  endtask

  initial begin
    int n;
    int pc;
    int rb;
    repeat (2) @(posedge clk);
    #1;
    outs_zero("reset");
    rst_n = 1'b1;
    spur_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // directed: two polls not ready, third ready, then 8190 back-to-back
    queue_meas(2, 8'h04, 16'h012C, 8'h00);
    queue_meas(0, 8'h01, 16'h1FFE, 8'h00);
    enable = 1'b1;
    init_done = 1'b1;
    drain_all(5000);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("period_stop_busy", busy, 0);
    check("range_8190", range_mm, 16'd8190);
    m_first = 1'b1;

    // timeout followed by a normal measurement
    queue_meas(MP, 8'h01, 16'h0000, 8'h00);
    queue_meas(1, 8'h03, 16'h00C8, 8'hFF);
    enable = 1'b1;
    stop_after();

    // randomized continuous run
    for (int i = 0; i < 8; i++) begin
      queue_meas($urandom_range(0, MP + 1),
                 (8'($urandom) & 8'hF8) | 8'($urandom_range(1, 7)),
                 16'($urandom), 8'hFF);
    end
    enable = 1'b1;
    stop_after();

    // enable and init_done dropped while polling
    queue_meas(1, 8'h02, 16'h0ABC, 8'hFF);
    pc = poll_seen;
    enable = 1'b1;
    n = 0;
    while (poll_seen == pc && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("poll_seen", {31'd0, poll_seen != pc}, 1);
    enable = 1'b0;
    init_done = 1'b0;
    drain_all(5000);
    repeat (P + 20) @(posedge clk);
    #1;
    check("drop_busy", busy, 0);
    check("drop_range", range_mm, 16'h0ABC);
    m_first = 1'b1;
    init_done = 1'b1;

    // reset during the result read after the high byte
    queue_meas(0, 8'h07, 16'h1234, 8'hFF);
    rb = res_bytes;
    enable = 1'b1;
    n = 0;
    while (res_bytes == rb && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("res_byte_seen", {31'd0, res_bytes != rb}, 1);
    @(posedge clk);
    #2;
    spur_en = 1'b0;
    rst_n = 1'b0;
    #1;
    outs_zero("async_rst");
    exp_ops.delete();
    exp_ev.delete();
    stat_q.delete();
    rng_q.delete();
    m_first = 1'b1;
    m_pub = 1'b0;
    m_range = '0;
    queue_meas(1, 8'h04, 16'h2222, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    inject = 1;
    spur_en = 1'b1;
    stop_after();

    check("ops_left", exp_ops.size(), 0);
    check("events_left", exp_ev.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
